// File: rtl/vga_timing_gen_param.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_param
//
// Parametrised VGA timing and test-pattern generator. A clock-enable divider
// derives the pixel rate from sys_clk. Horizontal and vertical counters walk
// the full raster (active + front porch + sync + back porch). On every pixel
// enable the registered outputs load the values for the current (x,y), so the
// outputs trail x/y by one pixel period and hold between enables.
//
// Ports
//   sys_clk      in   system clock
//   sys_rst      in   asynchronous reset, active low
//   mode         in   00 solid, 01 colour bars, 10 checkerboard, 11 external
//   solid_rgb    in   colour used in solid mode, {R,G,B}
//   ext_rgb      in   external pixel for (x,y), sampled on pix_ce
//   x, y         out  current horizontal / vertical counter (request coordinate)
//   pix_ce       out  pixel clock-enable, one sys_clk wide
//   h_sync       out  horizontal sync, active level HS_POL
//   v_sync       out  vertical sync, active level VS_POL
//   de           out  display enable
//   pixel_data   out  RGB pixel, zero outside active video
//   frame_start  out  one sys_clk pulse when pixel (0,0) appears on the outputs
//   frame_cnt    out  completed-frame counter, wraps at 16 bits
// -----------------------------------------------------------------------------
module vga_timing_gen_param #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter int COLOR_W  = 4,
    parameter int CHK_LOG2 = 5,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic                                                 sys_clk,
    input  logic                                                 sys_rst,
    input  logic [1:0]                                           mode,
    input  logic [3*COLOR_W-1:0]                                 solid_rgb,
    input  logic [3*COLOR_W-1:0]                                 ext_rgb,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]         x,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]         y,
    output logic                                                 pix_ce,
    output logic                                                 h_sync,
    output logic                                                 v_sync,
    output logic                                                 de,
    output logic [3*COLOR_W-1:0]                                 pixel_data,
    output logic                                                 frame_start,
    output logic [15:0]                                          frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int CW      = 3 * COLOR_W;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] BAR_LAST = HW'(BAR_W - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [HW-1:0] bar_px;      // pixel position inside the current bar
    logic [2:0]    bar_idx;     // current bar number, 0 = white
    logic [1:0]    mode_q;      // mode latched at the start of the frame
    logic          first_done;  // set once the first frame after reset began

    logic          line_end;
    logic          at_origin;
    logic          active;
    logic          hs_on;
    logic          vs_on;
    logic [1:0]    eff_mode;
    logic [CW-1:0] bar_rgb;
    logic [CW-1:0] pattern;

    assign pix_ce = (div == DIV_LAST);
    assign x      = hcnt;
    assign y      = vcnt;

    always_comb begin
        line_end  = (hcnt == H_LAST);
        at_origin = (hcnt == '0) && (vcnt == '0);
        // The origin pixel already uses the freshly sampled mode.
        eff_mode  = at_origin ? mode : mode_q;
        active    = (hcnt < H_ACT_L) && (vcnt < V_ACT_L);
        hs_on     = (hcnt >= HS_BEG) && (hcnt < HS_END);
        vs_on     = (vcnt >= VS_BEG) && (vcnt < VS_END);
        // Bar order white,yellow,cyan,green,magenta,red,blue,black:
        // R clears on idx bit1, G on idx bit2, B on idx bit0.
        bar_rgb   = {{COLOR_W{~bar_idx[1]}}, {COLOR_W{~bar_idx[2]}}, {COLOR_W{~bar_idx[0]}}};
        pattern   = '0;
        case (eff_mode)
            2'b00:   pattern = solid_rgb;
            2'b01:   pattern = bar_rgb;
            2'b10:   pattern = (hcnt[CHK_LOG2] ^ vcnt[CHK_LOG2]) ? {CW{1'b1}} : '0;
            default: pattern = ext_rgb;
        endcase
        if (!active) begin
            pattern = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            div         <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            bar_px      <= '0;
            bar_idx     <= '0;
            mode_q      <= 2'b00;
            first_done  <= 1'b0;
            de          <= 1'b0;
            h_sync      <= ~HS_POL;
            v_sync      <= ~VS_POL;
            pixel_data  <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_start <= 1'b0;
            if (pix_ce) begin
                div <= '0;
            end else begin
                div <= div + DW'(1);
            end

            if (pix_ce) begin
                de         <= active;
                h_sync     <= hs_on ? HS_POL : ~HS_POL;
                v_sync     <= vs_on ? VS_POL : ~VS_POL;
                pixel_data <= pattern;

                if (at_origin) begin
                    mode_q      <= mode;
                    frame_start <= 1'b1;
                    // The first frame after reset is not a completed frame.
                    if (first_done) begin
                        frame_cnt <= frame_cnt + 16'd1;
                    end
                    first_done  <= 1'b1;
                end

                if (line_end) begin
                    hcnt    <= '0;
                    bar_px  <= '0;
                    bar_idx <= '0;
                    vcnt    <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
                end else begin
                    hcnt <= hcnt + HW'(1);
                    // Bar index tracks hcnt/BAR_W without a divider.
                    if (bar_px == BAR_LAST) begin
                        bar_px  <= '0;
                        bar_idx <= bar_idx + 3'd1;
                    end else begin
                        bar_px  <= bar_px + HW'(1);
                    end
                end
            end
        end
    end

endmodule
